// File: rtl/counter_sched_pkg.sv
// Shared types and sizes for the counter scheduler slice.
package counter_sched_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int CNT_W = 4;
    localparam int REQ_N = 2;
endpackage

// File: rtl/counter_sched_if.sv
// Request/grant/status bundle between a requester side (master) and the scheduler (slave).
interface counter_sched_if;
    import counter_sched_pkg::*;
    logic             enable;
    logic [REQ_N-1:0] req;
    logic [CNT_W-1:0] len0;
    logic [CNT_W-1:0] len1;
    logic [REQ_N-1:0] gnt;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic [REQ_N-1:0] done;
    logic [CNT_W-1:0] count1;
    logic [CNT_W-1:0] count2;

    modport master (output enable, req, len0, len1,
                    input  gnt, count, busy, done, count1, count2);
    modport slave  (input  enable, req, len0, len1,
                    output gnt, count, busy, done, count1, count2);
endinterface

// File: rtl/counter_sched_counter_unit.sv
// Shared run counter: clear has priority over increment, otherwise hold; wraps at 2**W.
module counter_unit #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset)    count <= '0;
        else if (clr) count <= '0;
        else if (inc) count <= count + W'(1);
    end
endmodule

// File: rtl/counter_sched.sv
// Two-requester run scheduler with a shared counter and per-requester completion tallies.
// Define COUNTER_SCHED_RR_EN for round-robin arbitration; default is fixed priority (req[0] wins).
module counter_sched
    import counter_sched_pkg::*;
(
    input logic            clk,
    input logic            reset,
    counter_sched_if.slave bus
);
    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] last_cnt;
    logic             owner;
    logic             pick;
    logic             abort;
    logic             finish;
    logic             clr;
    logic             inc;
`ifdef COUNTER_SCHED_RR_EN
    logic             last_owner;
`endif

    // pick is the index of the winning requester; only meaningful when req != 0
    always_comb begin
`ifdef COUNTER_SCHED_RR_EN
        pick = (bus.req == 2'b11) ? ~last_owner : ~bus.req[0];
`else
        pick = ~bus.req[0];
`endif
    end

    always_comb begin
        last_cnt = len_q - CNT_W'(1);
        abort    = (state == RUN) && !bus.req[owner];
        finish   = (state == RUN) && bus.req[owner] && (bus.count == last_cnt);
        clr      = bus.enable && (abort || finish);
        inc      = bus.enable && (state == RUN) && !abort && !finish;
    end

    counter_unit #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (inc),
        .count (bus.count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            len_q      <= '0;
            bus.gnt    <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= '0;
            bus.count1 <= '0;
            bus.count2 <= '0;
`ifdef COUNTER_SCHED_RR_EN
            last_owner <= 1'b1;
`endif
        end else begin
            bus.done <= '0;
            unique case (state)
                IDLE: begin
                    if (bus.enable && bus.req != '0) begin
                        state    <= RUN;
                        owner    <= pick;
                        len_q    <= pick ? bus.len1 : bus.len0;
                        bus.gnt  <= {pick, ~pick};
                        bus.busy <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.enable) begin
                        if (abort) begin
                            state    <= IDLE;
                            bus.gnt  <= '0;
                            bus.busy <= 1'b0;
`ifdef COUNTER_SCHED_RR_EN
                            last_owner <= owner;
`endif
                        end else if (finish) begin
                            state    <= DONE;
                            bus.done <= bus.gnt;
                            if (owner) bus.count2 <= bus.count2 + CNT_W'(1);
                            else       bus.count1 <= bus.count1 + CNT_W'(1);
`ifdef COUNTER_SCHED_RR_EN
                            last_owner <= owner;
`endif
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_counter_sched.sv
// Directed self-checking bench for counter_sched; honours COUNTER_SCHED_RR_EN for arbitration expectations.
module tb_counter_sched;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] exp_c1 = '0;
    logic [3:0] exp_c2 = '0;

    counter_sched_if bus ();

    counter_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.enable = 1'b1; bus.req = 2'b00; bus.len0 = 4'd0; bus.len1 = 4'd0;
        tick();
        reset = 1'b0;
        checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected %b", bus.gnt, 2'b00); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected %0d", bus.count, 0); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected %b", bus.busy, 1'b0); end
        checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL reset_done: got %b expected %b", bus.done, 2'b00); end
        checks++; if (bus.count1 !== 4'd0) begin errors++; $display("FAIL reset_count1: got %0d expected %0d", bus.count1, 0); end
        checks++; if (bus.count2 !== 4'd0) begin errors++; $display("FAIL reset_count2: got %0d expected %0d", bus.count2, 0); end
    endtask

    task automatic test_basic();
        bus.req = 2'b01; bus.len0 = 4'd3;
        tick();
        checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL basic_gnt: got %b expected %b", bus.gnt, 2'b01); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected %b", bus.busy, 1'b1); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL basic_count0: got %0d expected %0d", bus.count, 0); end
        bus.len0 = 4'd9;  // must be ignored mid-run
        tick();
        checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL basic_count1: got %0d expected %0d", bus.count, 1); end
        tick();
        checks++; if (bus.count !== 4'd2) begin errors++; $display("FAIL basic_count2: got %0d expected %0d", bus.count, 2); end
        tick();
        exp_c1 = exp_c1 + 4'd1;
        checks++; if (bus.done !== 2'b01) begin errors++; $display("FAIL basic_done: got %b expected %b", bus.done, 2'b01); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL basic_done_count: got %0d expected %0d", bus.count, 0); end
        checks++; if (bus.count1 !== exp_c1) begin errors++; $display("FAIL basic_tally: got %0d expected %0d", bus.count1, exp_c1); end
        checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL basic_done_gnt: got %b expected %b", bus.gnt, 2'b01); end
        bus.req = 2'b00;
        tick();
        checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL basic_done_clear: got %b expected %b", bus.done, 2'b00); end
        checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL basic_idle_gnt: got %b expected %b", bus.gnt, 2'b00); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b expected %b", bus.busy, 1'b0); end
    endtask

    task automatic test_len16();
        bus.req = 2'b01; bus.len0 = 4'd0;
        tick();
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL len16_count0: got %0d expected %0d", bus.count, 0); end
        for (int i = 1; i < 16; i++) begin
            tick();
            checks++; if (bus.count !== 4'(i) || bus.done !== 2'b00) begin
                errors++; $display("FAIL len16_count: got %0d/done %b expected %0d/done 00", bus.count, bus.done, i);
            end
        end
        tick();
        exp_c1 = exp_c1 + 4'd1;
        checks++; if (bus.done !== 2'b01) begin errors++; $display("FAIL len16_done: got %b expected %b", bus.done, 2'b01); end
        checks++; if (bus.count1 !== exp_c1) begin errors++; $display("FAIL len16_tally: got %0d expected %0d", bus.count1, exp_c1); end
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_enable_hold();
        bus.req = 2'b01; bus.len0 = 4'd5;
        tick(); tick(); tick();
        checks++; if (bus.count !== 4'd2) begin errors++; $display("FAIL hold_pre: got %0d expected %0d", bus.count, 2); end
        bus.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.count !== 4'd2 || bus.gnt !== 2'b01) begin
                errors++; $display("FAIL hold_freeze: got count %0d gnt %b expected count 2 gnt 01", bus.count, bus.gnt);
            end
        end
        bus.enable = 1'b1;
        tick();
        checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL hold_resume: got %0d expected %0d", bus.count, 3); end
        tick(); tick();
        exp_c1 = exp_c1 + 4'd1;
        checks++; if (bus.done !== 2'b01) begin errors++; $display("FAIL hold_done: got %b expected %b", bus.done, 2'b01); end
        checks++; if (bus.count1 !== exp_c1) begin errors++; $display("FAIL hold_tally: got %0d expected %0d", bus.count1, exp_c1); end
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_c1 = '0; exp_c2 = '0;
        bus.req = 2'b11; bus.len0 = 4'd2; bus.len1 = 4'd2;
        for (int r = 0; r < 4; r++) begin
`ifdef COUNTER_SCHED_RR_EN
            exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            tick();
            checks++; if (bus.gnt !== exp_g) begin errors++; $display("FAIL b2b_gnt run%0d: got %b expected %b", r, bus.gnt, exp_g); end
            tick();
            checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL b2b_count run%0d: got %0d expected %0d", r, bus.count, 1); end
            tick();
            if (exp_g == 2'b01) exp_c1 = exp_c1 + 4'd1;
            else                exp_c2 = exp_c2 + 4'd1;
            checks++; if (bus.done !== exp_g) begin errors++; $display("FAIL b2b_done run%0d: got %b expected %b", r, bus.done, exp_g); end
            checks++; if (bus.count1 !== exp_c1 || bus.count2 !== exp_c2) begin
                errors++; $display("FAIL b2b_tally run%0d: got %0d/%0d expected %0d/%0d", r, bus.count1, bus.count2, exp_c1, exp_c2);
            end
            tick();
            checks++; if (bus.busy !== 1'b0 || bus.gnt !== 2'b00) begin
                errors++; $display("FAIL b2b_gap run%0d: got busy %b gnt %b expected busy 0 gnt 00", r, bus.busy, bus.gnt);
            end
        end
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_abort();
        bus.req = 2'b01; bus.len0 = 4'd4;
        tick(); tick();
        checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL abort_pre: got %0d expected %0d", bus.count, 1); end
        bus.req = 2'b00;
        tick();
        checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL abort_gnt: got %b expected %b", bus.gnt, 2'b00); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL abort_count: got %0d expected %0d", bus.count, 0); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected %b", bus.busy, 1'b0); end
        checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL abort_done: got %b expected %b", bus.done, 2'b00); end
        checks++; if (bus.count1 !== exp_c1) begin errors++; $display("FAIL abort_tally: got %0d expected %0d", bus.count1, exp_c1); end
        tick();
        checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL abort_late_done: got %b expected %b", bus.done, 2'b00); end
    endtask

    task automatic test_reset_midrun();
        bus.req = 2'b10; bus.len1 = 4'd6;
        tick();
        checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL rmid_gnt: got %b expected %b", bus.gnt, 2'b10); end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; bus.req = 2'b00;
        checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL rmid_gnt0: got %b expected %b", bus.gnt, 2'b00); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL rmid_count: got %0d expected %0d", bus.count, 0); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected %b", bus.busy, 1'b0); end
        checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL rmid_done: got %b expected %b", bus.done, 2'b00); end
        checks++; if (bus.count1 !== 4'd0 || bus.count2 !== 4'd0) begin
            errors++; $display("FAIL rmid_tally: got %0d/%0d expected 0/0", bus.count1, bus.count2);
        end
        tick();
        checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL rmid_no_done: got %b expected %b", bus.done, 2'b00); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len16();
        test_enable_hold();
        test_back_to_back();
        test_abort();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/counter_sched.md
COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled on the clk rising edge.
REQ-004 enable  input  1  global advance; when low, the FSM and the counter hold their values.
REQ-005 req  input  2  level request per requester; held high until done, dropping it aborts the run.
REQ-006 len0, len1  input  4 each  run length for requester 0/1; sampled at grant; 0 means 16.
REQ-007 gnt  output  2  one-hot owner, registered; high through RUN and DONE.
REQ-008 count  output  4  shared counter value; 0 when not in RUN.
REQ-009 busy  output  1  high in RUN or DONE.
REQ-010 done  output  2  one-cycle pulse to the owner in DONE.
REQ-011 count1, count2  output  4 each  completed-run tallies for requester 0/1; wrap 15->0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE->RUN occurs on an edge with enable=1, reset=0 and req!=0; at that edge the block SHALL set gnt, latch len and set count=0.
REQ-014 The grant SHALL be visible one cycle after req is sampled; there are no combinational req->gnt paths.
REQ-015 In RUN with enable=1, count SHALL increment by 1 per cycle; with enable=0 all state SHALL hold.
REQ-016 RUN->DONE occurs when enable=1 and count==len_latched-1 (mod 16); len=0 therefore gives 16 RUN cycles (count 0..15).
REQ-017 DONE SHALL last one cycle regardless of enable; in it, done[owner]=1 and the owner's tally increments; DONE->IDLE follows.
REQ-018 Abort: if req[owner]=0 in RUN, the block SHALL go to IDLE next edge, with gnt=0, count=0, no done and no tally change.
REQ-019 A req held through DONE SHALL be re-arbitrated from IDLE; the minimum gap between runs is one IDLE cycle.
REQ-020 Arbitration SHALL be per REQ-026/027; a single requester is always granted.
REQ-021 len changes during RUN SHALL have no effect.

Reset
REQ-022 With reset=1 at an edge, the block SHALL force IDLE, gnt=0, count=0, busy=0, done=0, count1=0, count2=0 and last_owner=1 (requester 0 wins first).
REQ-023 Reset SHALL override enable and take effect mid-RUN or in DONE; an interrupted run produces no done pulse.
REQ-024 All outputs SHALL be defined (no X) from the first edge with reset=1.

Configuration
REQ-025 The macro COUNTER_SCHED_RR_EN SHALL select the arbitration policy.
REQ-026 With COUNTER_SCHED_RR_EN defined: round-robin; on req=2'b11, grant the requester that is not last_owner; last_owner updates in DONE and on abort.
REQ-027 Without COUNTER_SCHED_RR_EN: fixed priority, with req[0] winning; last_owner is not implemented.

Structure
REQ-028 A package counter_sched_pkg SHALL hold the state enum (IDLE/RUN/DONE), CNT_W=4 and REQ_N=2.
REQ-029 The shared counter SHALL be one sub-module, counter_unit: clear, increment and hold, with a 4-bit wrap.
REQ-030 The FSM, arbiter, len latch and tallies SHALL reside in counter_sched.

Verification
REQ-031 Reset then req=01, len0=3, enable=1 -> gnt=01 after 1 edge; count 0,1,2; done=01 for 1 cycle; count1=1; IDLE.
REQ-032 req=01, len0=0 -> 16 RUN cycles with count 0..15, then a done pulse; count1 increments.
REQ-033 enable=0 for 5 cycles mid-RUN at count=2 -> count stays 2 and gnt is unchanged; on resume, count 3 follows.
REQ-034 With RR_EN, req=11 held, len0=len1=2 -> grants alternate 01,10,01; count1 and count2 both reach 2 after 4 runs; without RR_EN, only 01 is granted.
REQ-035 req[0] dropped at count=1 -> IDLE next edge, no done, count1 unchanged; reset asserted mid-RUN -> all outputs 0 next edge.
